// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: deframer state encoding,
// scan-code constants used by the keyboard consumer, and a parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Prefix bytes the CPU side watches for in the scan-code stream.
  localparam logic [7:0] BREAK  = 8'hF0;
  localparam logic [7:0] EXTEND = 8'hE0;

  // True when the 8 data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Consumer-side bundle of the PS/2 receiver: scan-code handshake plus the
// one-cycle error/overflow pulses. The receiver is the master.
interface ps2_rx_if;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  modport master (
    output code, code_valid, parity_err, frame_err, overflow,
    input  code_ready
  );

  modport slave (
    input  code, code_valid, parity_err, frame_err, overflow,
    output code_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Small circular FIFO with show-ahead head output. Pointers carry one extra
// MSB so full and empty are distinguishable without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A ready while empty is simply ignored.
  assign pop     = pop_req & ~empty;
  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | pop);

  // Head is forced to zero when empty so the output is clean out of reset.
  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign not_empty = ~empty;

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update and one-cycle overflow pulse for a dropped push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and debounces the pins, detects
// falling edges of the filtered clock, deframes 11-bit frames and queues
// good scan codes for the CPU. Never drives the PS/2 lines.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  ps2_rx_if.master  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST   = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  // Index 0 is ps2_clk, index 1 is ps2_data.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic          clk_sync;
  logic          data_sync;

  logic          filt_clk;
  logic          filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall_edge;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          push;
  logic [7:0]    push_data;
  logic          parity_err;
  logic          frame_err;

  assign clk_sync  = sync2[0];
  assign data_sync = sync2[1];
  assign fall_edge = filt_prev & ~filt_clk;

  // Two-stage synchronisers for both pins; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {ps2_data, ps2_clk};
      sync2 <= sync1;
    end
  end

  // Debounce: flip the filtered clock only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync != filt_clk) begin
        if (filt_cnt == FILT_LAST) begin
          filt_clk <= clk_sync;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Deframer FSM with inactivity timeout; error and push outputs are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      timer      <= '0;
      push       <= 1'b0;
      push_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (fall_edge) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift[bit_cnt] <= data_sync;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            par_bit <= data_sync;
            state   <= STOP;
          end
          STOP: begin
            // A bad stop bit outranks a bad parity bit.
            if (!data_sync) begin
              frame_err <= 1'b1;
            end else if (!odd_parity_ok(shift, par_bit)) begin
              parity_err <= 1'b1;
            end else begin
              push      <= 1'b1;
              push_data <= shift;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        timer <= '0;
      end else if (timer == TIMEOUT_MAX) begin
        // Device stalled mid-frame: abandon the partial frame.
        state     <= IDLE;
        timer     <= '0;
        frame_err <= 1'b1;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop_req   (bus.code_ready),
    .head      (bus.code),
    .not_empty (bus.code_valid),
    .overflow  (bus.overflow)
  );

  assign bus.parity_err = parity_err;
  assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed plus randomized bench for ps2_rx: frames are bit-banged on the
// PS/2 pins and outcomes are compared against a queue-based frame model.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FL   = 4;
  localparam int TO   = 2000;
  localparam int HALF = 100;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_if bus();

  ps2_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, sampled on the falling clock edge.
  int         perr_cnt   = 0;
  int         ferr_cnt   = 0;
  int         ovf_cnt    = 0;
  logic       prev_valid = 1'b0;
  int         rise_cyc   = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (bus.parity_err) perr_cnt <= perr_cnt + 1;
    if (bus.frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (bus.overflow)   ovf_cnt  <= ovf_cnt + 1;
    if (bus.code_valid && bus.code_ready) got_q.push_back(bus.code);
    if (bus.code_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= bus.code_valid;
  end

  // Reference model: FIFO contents and expected pulse totals.
  logic [7:0] mq[$];
  int perr_exp = 0;
  int ferr_exp = 0;
  int ovf_exp  = 0;
  int stop_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Bit-bang a frame; nbits < 11 sends only the leading part.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit pop_at_push);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HALF / 2);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      if (i == 10 && pop_at_push) begin
        // Push is seen by the FIFO 7 cycles after the stop fall is driven.
        tick(7);
        bus.code_ready = 1'b1;
        tick(1);
        bus.code_ready = 1'b0;
        tick(HALF - 8);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
      tick(HALF / 2);
    end
    ps2_data = 1'b1;
    tick(20);
  endtask

  // Outcome of one complete frame by the framing rules.
  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input bit concurrent_pop);
    int occ;
    if (bad_stop) ferr_exp++;
    else if (bad_par) perr_exp++;
    else begin
      occ = mq.size() - (concurrent_pop ? 1 : 0);
      if (occ >= 4) ovf_exp++;
      else mq.push_back(d);
    end
  endtask

  // Compare every observed pop with the model, then the pulse totals.
  task automatic reconcile(input string tag);
    logic [31:0] exp;
    while (got_q.size() > 0) begin
      exp = (mq.size() > 0) ? {24'd0, mq.pop_front()} : 'x;
      check({tag, "_pop"}, {24'd0, got_q.pop_front()}, exp);
    end
    check({tag, "_parity_err"}, perr_cnt, perr_exp);
    check({tag, "_frame_err"},  ferr_cnt, ferr_exp);
    check({tag, "_overflow"},   ovf_cnt,  ovf_exp);
  endtask

  task automatic drain(input string tag);
    bus.code_ready = 1'b1;
    tick(10);
    bus.code_ready = 1'b0;
    tick(2);
    reconcile(tag);
    check({tag, "_empty"}, bus.code_valid, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int r;
    bus.code_ready = 1'b0;

    // Reset state
    tick(3);
    check("rst_valid", bus.code_valid, 1'b0);
    check("rst_code",  bus.code, 8'h00);
    check("rst_perr",  bus.parity_err, 1'b0);
    check("rst_ferr",  bus.frame_err, 1'b0);
    check("rst_ovf",   bus.overflow, 1'b0);
    rst = 1'b0;
    tick(5);

    // Single good frame, held at the head
    send_frame(8'h1C, 0, 0, 11, 0);
    model_frame(8'h1C, 0, 0, 0);
    check("lat_1c", rise_cyc - stop_cyc, 8);
    check("valid_1c", bus.code_valid, 1'b1);
    check("code_1c", bus.code, 8'h1C);
    reconcile("t1");
    drain("t1");

    // Two frames with the consumer always ready
    bus.code_ready = 1'b1;
    send_frame(BREAK, 0, 0, 11, 0);
    model_frame(BREAK, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 11, 0);
    model_frame(8'h1C, 0, 0, 0);
    bus.code_ready = 1'b0;
    reconcile("t2");
    check("t2_valid", bus.code_valid, 1'b0);

    // Parity error
    send_frame(8'h1C, 1, 0, 11, 0);
    model_frame(8'h1C, 1, 0, 0);
    check("t3_valid", bus.code_valid, 1'b0);
    reconcile("t3");

    // Stop-bit error
    send_frame(8'h1C, 0, 1, 11, 0);
    model_frame(8'h1C, 0, 1, 0);
    reconcile("t4a");

    // Partial frame abandoned by timeout, then a good frame
    send_frame(8'h5A, 0, 0, 4, 0);
    tick(2500);
    ferr_exp++;
    reconcile("t4b");
    send_frame(8'h5A, 0, 0, 11, 0);
    model_frame(8'h5A, 0, 0, 0);
    check("code_5a", bus.code, 8'h5A);
    drain("t4c");

    // Overflow on the fifth frame
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0, 0, 11, 0);
      model_frame(8'(i), 0, 0, 0);
    end
    check("t5_ovf_cnt", ovf_cnt, ovf_exp);
    check("t5_head", bus.code, 8'h01);
    tick(30);
    check("t5_head_hold", bus.code, 8'h01);
    drain("t5");

    // Pop lands in the push cycle while full
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 0, 0, 11, 0);
      model_frame(8'(i), 0, 0, 0);
    end
    send_frame(8'h06, 0, 0, 11, 1);
    model_frame(8'h06, 0, 0, 1);
    check("t6_no_ovf", ovf_cnt, ovf_exp);
    drain("t6");

    // Reset in the middle of a frame
    send_frame(8'h11, 0, 0, 11, 0);
    model_frame(8'h11, 0, 0, 0);
    check("t7_pre_valid", bus.code_valid, 1'b1);
    send_frame(8'h77, 0, 0, 5, 0);
    rst = 1'b1;
    tick(3);
    check("t7_valid", bus.code_valid, 1'b0);
    check("t7_code", bus.code, 8'h00);
    check("t7_errs", {bus.parity_err, bus.frame_err, bus.overflow}, 3'b000);
    rst = 1'b0;
    mq.delete();
    tick(5);
    send_frame(8'h29, 0, 0, 11, 0);
    model_frame(8'h29, 0, 0, 0);
    check("code_29", bus.code, 8'h29);
    drain("t7");

    // Short glitches on ps2_clk must not register as edges
    ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      tick(FL - 1);
      ps2_clk = 1'b1;
      tick(20);
    end
    ps2_data = 1'b1;
    tick(2100);
    check("t8_valid", bus.code_valid, 1'b0);
    reconcile("t8");

    // Randomized frames with random corruption, consumer always ready
    bus.code_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd = (i == 0) ? EXTEND : 8'($urandom);
      r  = int'($urandom_range(0, 3));
      send_frame(rd, r[0], r[1], 11, 0);
      model_frame(rd, r[0], r[1], 0);
      reconcile("rnd");
    end
    bus.code_ready = 1'b0;
    tick(5);
    check("rnd_valid", bus.code_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
